cripto_core: RTL and testbench

//  Iterative 64-bit block cipher core: GOST R 34.12-2015 "Magma" (RFC 8891), 256-bit key, 32 rounds.

---
 rtl/cripto_core.sv | 119 +++++++++++
 tb/tb_cripto_core.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cripto_core.sv
// Iterative GOST R 34.12-2015 "Magma" block cipher core: 64-bit block, 256-bit key,
// 32 rounds executed one per clock behind a start/busy/ready handshake.
module cripto_core (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         enc_dec,
  input  logic [63:0]  data_i,
  input  logic [255:0] key_i,
  output logic [63:0]  data_o,
  output logic         busy,
  output logic         ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Eight 4-bit permutations, P7 in the top 64 bits; entry n of Pj sits at bits [j*64 + n*4 +: 4].
  localparam logic [511:0] SBOX = {
    64'h2BC96AF43850DE71,  // P7
    64'h73AD0B4FC19652E8,  // P6
    64'h0E34187BAC296FD5,  // P5
    64'hC24BE390D618A5F7,  // P4
    64'hB9E35A076F4D128C,  // P3
    64'h069C471EDAF2853B,  // P2
    64'hF0DB74E1C5A93286,  // P1
    64'h1F307D8E9B5A264C   // P0
  };

  state_t         state;
  logic [4:0]     cnt;
  logic           mode;
  logic [255:0]   key_r;
  logic [31:0]    a1;
  logic [31:0]    a0;

  logic [2:0]     key_idx;
  logic [31:0]    round_key;
  logic [31:0]    f_out;

  // g(a,k) = rotl11(t(a + k mod 2^32))
  function automatic logic [31:0] g_fn(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] s;
    logic [31:0] t;
    logic [8:0]  idx;
    s = a + k;
    t = '0;
    for (int j = 0; j < 8; j++) begin
      idx = {3'(j), s[4*j +: 4], 2'b00};
      t[4*j +: 4] = SBOX[idx +: 4];
    end
    return {t[20:0], t[31:21]};
  endfunction

  // Key word 0..7 (K1..K8): forward order first, reversed order for the last
  // 8 rounds when encrypting and for the last 24 rounds when decrypting.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    key_idx = cnt[2:0];
    if (mode ? (cnt >= 5'd24) : (cnt >= 5'd8)) begin
      key_idx = ~cnt[2:0];
    end
    round_key = key_r[{~key_idx, 5'd0} +: 32];
    f_out     = g_fn(a0, round_key) ^ a1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mode   <= 1'b0;
      key_r  <= '0;
      a1     <= '0;
      a0     <= '0;
      data_o <= '0;
      busy   <= 1'b0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode  <= enc_dec;
            key_r <= key_i;
            a1    <= data_i[63:32];
            a0    <= data_i[31:0];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ROUND;
          end
        end
        ROUND: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            // Last round: no swap, the block is left as {g(a0,k)^a1, a0}.
            a1    <= f_out;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            a1 <= a0;
            a0 <= f_out;
          end
        end
        DONE: begin
          data_o <= {a1, a0};
          ready  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cripto_core.sv
// Self-checking bench for cripto_core: table-driven blocks with a scoreboard queue,
// plus hand-written sequences for reset abort and back-to-back start.
module tb_cripto_core;

  typedef struct {
    logic         enc;
    logic [255:0] key;
    logic [63:0]  data;
    logic [63:0]  exp;
    bit           noise;
  } vec_t;

  localparam logic [255:0] KEY_KAT =
    256'hFFEEDDCCBBAA99887766554433221100F0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
  localparam logic [255:0] KEY_RT =
    256'hDEADBEEF0123456789ABCDEFDEADBEEFDEADBEEF0123456789ABCDEFDEADBEEF;
  localparam logic [63:0] PT_KAT = 64'hFEDCBA9876543210;
  localparam logic [63:0] CT_KAT = 64'h4EE901E5C2D8CA3D;

  // Permutations exactly as listed for the algorithm, entry 0 first.
  localparam logic [3:0] PI [8][16] = '{
    '{4'hC,4'h4,4'h6,4'h2,4'hA,4'h5,4'hB,4'h9,4'hE,4'h8,4'hD,4'h7,4'h0,4'h3,4'hF,4'h1},
    '{4'h6,4'h8,4'h2,4'h3,4'h9,4'hA,4'h5,4'hC,4'h1,4'hE,4'h4,4'h7,4'hB,4'hD,4'h0,4'hF},
    '{4'hB,4'h3,4'h5,4'h8,4'h2,4'hF,4'hA,4'hD,4'hE,4'h1,4'h7,4'h4,4'hC,4'h9,4'h6,4'h0},
    '{4'hC,4'h8,4'h2,4'h1,4'hD,4'h4,4'hF,4'h6,4'h7,4'h0,4'hA,4'h5,4'h3,4'hE,4'h9,4'hB},
    '{4'h7,4'hF,4'h5,4'hA,4'h8,4'h1,4'h6,4'hD,4'h0,4'h9,4'h3,4'hE,4'hB,4'h4,4'h2,4'hC},
    '{4'h5,4'hD,4'hF,4'h6,4'h9,4'h2,4'hC,4'hA,4'hB,4'h7,4'h8,4'h1,4'h4,4'h3,4'hE,4'h0},
    '{4'h8,4'hE,4'h2,4'h5,4'h6,4'h9,4'h1,4'hC,4'hF,4'h4,4'hB,4'h0,4'hD,4'hA,4'h3,4'h7},
    '{4'h1,4'h7,4'hE,4'hD,4'h0,4'h5,4'h8,4'h3,4'h4,4'hF,4'hA,4'h6,4'h9,4'hC,4'hB,4'h2}
  };

  logic         clock;
  logic         reset;
  logic         start;
  logic         enc_dec;
  logic [63:0]  data_i;
  logic [255:0] key_i;
  logic [63:0]  data_o;
  logic         busy;
  logic         ready;

  int           n_checks;
  int           n_fail;
  logic [63:0]  exp_q [$];
  vec_t         vecs [$];

  cripto_core dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .enc_dec (enc_dec),
    .data_i  (data_i),
    .key_i   (key_i),
    .data_o  (data_o),
    .busy    (busy),
    .ready   (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] s;
    logic [31:0] t;
    s = a + k;
    t = '0;
    for (int j = 0; j < 8; j++) t[4*j +: 4] = PI[j][s[4*j +: 4]];
    return (t << 11) | (t >> 21);
  endfunction

  function automatic logic [63:0] magma_ref(input logic enc, input logic [255:0] key,
                                            input logic [63:0] blk);
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] tmp;
    int          w;
    hi = blk[63:32];
    lo = blk[31:0];
    for (int i = 0; i < 32; i++) begin
      if (enc) w = (i < 24) ? (i % 8) : (31 - i);
      else     w = (i < 8)  ? i       : (7 - (i % 8));
      tmp = ref_g(lo, key[255 - 32*w -: 32]) ^ hi;
      if (i == 31) return {tmp, lo};
      hi = lo;
      lo = tmp;
    end
    return '0;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block: drive, push expectation, watch busy/ready, pop and compare.
  task automatic run_block(input vec_t v, input string tag);
    int          edges;
    int          busy_cnt;
    logic [63:0] exp;
    @(negedge clock);
    enc_dec = v.enc;
    key_i   = v.key;
    data_i  = v.data;
    start   = 1'b1;
    exp_q.push_back(v.exp);
    @(negedge clock);
    start    = 1'b0;
    edges    = 0;
    busy_cnt = 0;
    while (!ready && edges < 80) begin
      if (busy) busy_cnt++;
      if (v.noise) begin
        start   = 1'($urandom_range(0, 1));
        enc_dec = 1'($urandom_range(0, 1));
        data_i  = {$urandom, $urandom};
        key_i   = rand256();
      end
      @(negedge clock);
      edges++;
    end
    start = 1'b0;
    check({tag, "_ready_seen"}, 64'(ready), 64'd1);
    exp = exp_q.pop_front();
    if (ready) begin
      check({tag, "_latency"}, 64'(edges), 64'd33);
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
      check({tag, "_data_o"}, data_o, exp);
      @(negedge clock);
      check({tag, "_ready_one_cycle"}, 64'(ready), 64'd0);
      check({tag, "_data_o_held"}, data_o, exp);
    end
  endtask

  initial begin
    logic [63:0] c_rt;
    logic [63:0] d_rnd;
    logic [255:0] k_rnd;
    logic [63:0] last;
    int          got;
    int          first_at;
    int          second_at;
    int          ready_cnt;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    enc_dec  = 1'b0;
    data_i   = '0;
    key_i    = '0;

    repeat (3) @(negedge clock);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_data_o", data_o, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_busy", 64'(busy), 64'd0);

    c_rt  = magma_ref(1'b1, KEY_RT, 64'hA5A5A5A501234567);
    k_rnd = rand256();
    d_rnd = {$urandom, $urandom};
    vecs.push_back('{enc: 1'b1, key: KEY_KAT, data: PT_KAT, exp: CT_KAT, noise: 1'b0});
    vecs.push_back('{enc: 1'b0, key: KEY_KAT, data: CT_KAT, exp: PT_KAT, noise: 1'b1});
    vecs.push_back('{enc: 1'b1, key: KEY_RT, data: 64'hA5A5A5A501234567, exp: c_rt, noise: 1'b1});
    vecs.push_back('{enc: 1'b0, key: KEY_RT, data: c_rt, exp: 64'hA5A5A5A501234567, noise: 1'b0});
    vecs.push_back('{enc: 1'b1, key: k_rnd, data: d_rnd, exp: magma_ref(1'b1, k_rnd, d_rnd), noise: 1'b0});
    vecs.push_back('{enc: 1'b0, key: k_rnd, data: magma_ref(1'b1, k_rnd, d_rnd), exp: d_rnd, noise: 1'b1});

    foreach (vecs[i]) run_block(vecs[i], $sformatf("vec%0d", i));

    // Idle with changing inputs but no start: output must not move.
    last = d_rnd;
    repeat (5) begin
      @(negedge clock);
      data_i = {$urandom, $urandom};
      key_i  = rand256();
    end
    @(negedge clock);
    check("idle_hold_data_o", data_o, last);
    check("idle_hold_busy", 64'(busy), 64'd0);

    // Reset in the middle of a block: abort, outputs back to zero, no ready afterwards.
    @(negedge clock);
    enc_dec = 1'b1;
    key_i   = KEY_KAT;
    data_i  = PT_KAT;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("abort_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(ready), 64'd0);
    check("abort_data_o", data_o, 64'd0);
    @(negedge clock);
    reset     = 1'b1;
    ready_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ready) ready_cnt++;
    end
    check("abort_no_ready", 64'(ready_cnt), 64'd0);
    run_block('{enc: 1'b1, key: KEY_KAT, data: PT_KAT, exp: CT_KAT, noise: 1'b0}, "post_reset");

    // start held high: blocks restart as soon as IDLE is re-entered.
    @(negedge clock);
    enc_dec = 1'b1;
    key_i   = KEY_KAT;
    data_i  = PT_KAT;
    start   = 1'b1;
    exp_q.push_back(CT_KAT);
    exp_q.push_back(CT_KAT);
    got       = 0;
    first_at  = 0;
    second_at = 0;
    for (int i = 0; i < 120 && got < 2; i++) begin
      @(negedge clock);
      if (ready) begin
        got++;
        if (got == 1) first_at = i;
        else          second_at = i;
        check($sformatf("held_start_data_o%0d", got), data_o, exp_q.pop_front());
      end
    end
    start = 1'b0;
    check("held_start_blocks", 64'(got), 64'd2);
    check("held_start_gap", 64'(second_at - first_at), 64'd34);
    @(negedge clock);
    check("held_start_stop_busy", 64'(busy), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
